csr_irq_file: RTL and testbench

Machine-mode control/status register file for the OTTER multicycle core, successor to the single-interrupt CSR unit. It supports `NUM_IRQ` prioritised, level-sensitive interrupt lines with input synchronisers and vectored or direct trap entry. It implements CSRRW/CSRRS/CSRRC semantics and provides MIE/MPIE stacking across trap and `mret`, plus 64-bit `mcycle`/`minstret` counters. It sits beside the register file; the control FSM samples `int_req` and `int_vec` and drives `int_taken`, `int_ret` and `instr_retire`.

---
 rtl/csr_irq_file.sv | 190 +++++++++++++++++++
 tb/tb_csr_irq_file.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_file.sv
// Machine-mode CSR file with prioritised level-sensitive interrupts,
// trap entry/return stacking and 64-bit cycle/instret counters.
module csr_irq_file #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned COUNTERS_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        addr,
  input  logic [31:0]        wd,
  input  logic [31:0]        next_pc,
  input  logic               int_taken,
  input  logic               int_ret,
  input  logic               instr_retire,
  output logic [31:0]        rd,
  output logic               csr_illegal,
  output logic [31:0]        mepc,
  output logic               int_req,
  output logic [31:0]        int_vec
);

  localparam int unsigned IDX_W  = 4;
  localparam logic        CNT_ON = 1'(COUNTERS_EN != 0);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic [NUM_IRQ-1:0] irq_s1, mip_q, mie_q, pending;
  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]        mcycle_q, minstret_q;

  logic [31:0]        mie_word, mip_word, old, wv, cause_code;
  logic               mapped, ro, nop_mask, wr_en, trap, any_pend;
  logic [IDX_W-1:0]   idx;

  // Place the per-line bits at their architectural positions
  always_comb begin
    mie_word = '0;
    mip_word = '0;
    mie_word[16 +: NUM_IRQ] = mie_q;
    mip_word[16 +: NUM_IRQ] = mip_q;
  end

  // Address decode and old-value read mux
  always_comb begin
    mapped = 1'b1;
    ro     = 1'b0;
    old    = '0;
    case (addr)
      A_MSTATUS:   old = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      A_MIE:       old = mie_word;
      A_MTVEC:     old = mtvec_q;
      A_MSCRATCH:  old = mscratch_q;
      A_MEPC:      old = mepc_q;
      A_MCAUSE:    old = mcause_q;
      A_MIP:       begin old = mip_word; ro = 1'b1; end
      A_MCYCLE:    begin old = mcycle_q[31:0];    mapped = CNT_ON; end
      A_MCYCLEH:   begin old = mcycle_q[63:32];   mapped = CNT_ON; end
      A_MINSTRET:  begin old = minstret_q[31:0];  mapped = CNT_ON; end
      A_MINSTRETH: begin old = minstret_q[63:32]; mapped = CNT_ON; end
      A_CYCLE:     begin old = mcycle_q[31:0];    mapped = CNT_ON; ro = 1'b1; end
      A_CYCLEH:    begin old = mcycle_q[63:32];   mapped = CNT_ON; ro = 1'b1; end
      A_INSTRET:   begin old = minstret_q[31:0];  mapped = CNT_ON; ro = 1'b1; end
      A_INSTRETH:  begin old = minstret_q[63:32]; mapped = CNT_ON; ro = 1'b1; end
      default:     mapped = 1'b0;
    endcase
    if (!mapped) old = '0;
  end

  assign rd = old;

  // RS/RC with an empty mask is a pure read and never faults
  assign nop_mask    = csr_op[1] & (wd == '0);
  assign csr_illegal = (csr_op != OP_NONE) & ~nop_mask & (~mapped | ro);
  assign wr_en       = (csr_op != OP_NONE) & ~nop_mask & mapped & ~ro & ~trap;

  // New value for RW / RS / RC
  always_comb begin
    case (csr_op)
      OP_RW:   wv = wd;
      OP_RS:   wv = old | wd;
      default: wv = old & ~wd;
    endcase
  end

  // Lowest pending line index wins
  always_comb begin
    pending  = mip_q & mie_q;
    any_pend = |pending;
    idx      = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) idx = IDX_W'(i);
    end
  end

  assign cause_code = 32'(idx) + 32'd16;
  assign int_req    = mstatus_mie & any_pend;
  assign trap       = int_taken & int_req;
  assign int_vec    = {mtvec_q[31:2], 2'b00} +
                      ((mtvec_q[0] & any_pend) ? (cause_code << 2) : 32'd0);
  assign mepc       = mepc_q;

  // Two-flop synchroniser per interrupt line
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1 <= '0;
      mip_q  <= '0;
    end else begin
      irq_s1 <= irq;
      mip_q  <= irq_s1;
    end
  end

  // mstatus: trap stacking beats mret, which beats a software write
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (int_ret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en && addr == A_MSTATUS) begin
      mstatus_mie  <= wv[3];
      mstatus_mpie <= wv[7];
    end
  end

  // Plain CSRs plus trap capture of mepc/mcause
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap) begin
      mepc_q   <= next_pc & 32'hFFFF_FFFC;
      mcause_q <= 32'h8000_0000 | cause_code;
    end else if (wr_en) begin
      case (addr)
        A_MIE:      mie_q      <= wv[16 +: NUM_IRQ];
        A_MTVEC:    mtvec_q    <= {wv[31:2], 1'b0, (wv[1:0] == 2'b01)};
        A_MSCRATCH: mscratch_q <= wv;
        A_MEPC:     mepc_q     <= wv & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause_q   <= wv;
        default:    ;
      endcase
    end
  end

  // 64-bit counters; a write to either half replaces the increment
  always_ff @(posedge clk) begin
    if (rst || !CNT_ON) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && addr == A_MCYCLE)       mcycle_q[31:0]  <= wv;
      else if (wr_en && addr == A_MCYCLEH) mcycle_q[63:32] <= wv;
      else                                 mcycle_q        <= mcycle_q + 64'd1;

      if (wr_en && addr == A_MINSTRET)       minstret_q[31:0]  <= wv;
      else if (wr_en && addr == A_MINSTRETH) minstret_q[63:32] <= wv;
      else if (instr_retire)                 minstret_q        <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_irq_file.sv
// Bench for csr_irq_file: directed scenarios plus random traffic against
// a cycle-level behavioural model of the CSR/interrupt rules.
module tb_csr_irq_file;

  localparam int unsigned NI = 4;
  localparam logic [31:0] MIE_MASK = 32'((2 ** NI) - 1) << 16;

  logic          clk;
  logic          rst;
  logic [NI-1:0] irq;
  logic [1:0]    csr_op;
  logic [11:0]   addr;
  logic [31:0]   wd, next_pc;
  logic          int_taken, int_ret, instr_retire;
  logic [31:0]   rd, mepc, int_vec;
  logic          csr_illegal, int_req;

  csr_irq_file #(.NUM_IRQ(NI), .COUNTERS_EN(1)) dut (
    .clk(clk), .rst(rst), .irq(irq), .csr_op(csr_op), .addr(addr), .wd(wd),
    .next_pc(next_pc), .int_taken(int_taken), .int_ret(int_ret),
    .instr_retire(instr_retire), .rd(rd), .csr_illegal(csr_illegal),
    .mepc(mepc), .int_req(int_req), .int_vec(int_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic          mm_ie, mm_pie;
  logic [31:0]   mm_mie, mm_tvec, mm_scr, mm_epc, mm_cause;
  logic [63:0]   mm_cyc, mm_ret;
  logic [NI-1:0] irq_d1, irq_d2;

  function automatic void m_lookup(input logic [11:0] a, output bit mp,
                                   output bit ro, output logic [31:0] v);
    mp = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'h300: v = {24'd0, mm_pie, 3'd0, mm_ie, 3'd0};
      12'h304: v = mm_mie;
      12'h305: v = mm_tvec;
      12'h340: v = mm_scr;
      12'h341: v = mm_epc;
      12'h342: v = mm_cause;
      12'h344: begin v = 32'(irq_d2) << 16; ro = 1'b1; end
      12'hB00: v = mm_cyc[31:0];
      12'hB80: v = mm_cyc[63:32];
      12'hB02: v = mm_ret[31:0];
      12'hB82: v = mm_ret[63:32];
      12'hC00: begin v = mm_cyc[31:0];  ro = 1'b1; end
      12'hC80: begin v = mm_cyc[63:32]; ro = 1'b1; end
      12'hC02: begin v = mm_ret[31:0];  ro = 1'b1; end
      12'hC82: begin v = mm_ret[63:32]; ro = 1'b1; end
      default: mp = 1'b0;
    endcase
  endfunction

  function automatic int m_idx();
    for (int i = 0; i < int'(NI); i++)
      if (irq_d2[i] && mm_mie[16+i]) return i;
    return -1;
  endfunction

  function automatic bit m_illegal(input bit mp, input bit ro);
    if (csr_op == 2'b00) return 1'b0;
    if (csr_op != 2'b01 && wd == 32'd0) return 1'b0;
    return !mp || ro;
  endfunction

  // Compare every observable output against the model
  task automatic check_outputs();
    bit mp, ro;
    logic [31:0] v, vec;
    int k;
    m_lookup(addr, mp, ro, v);
    k = m_idx();
    vec = {mm_tvec[31:2], 2'b00};
    if (mm_tvec[1:0] == 2'b01 && k >= 0) vec = vec + 32'(4 * (16 + k));
    chk("rd", rd, mp ? v : 32'd0);
    chk("csr_illegal", csr_illegal, m_illegal(mp, ro));
    chk("mepc", mepc, mm_epc);
    chk("int_req", int_req, mm_ie && k >= 0);
    chk("int_vec", int_vec, vec);
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic m_step();
    bit mp, ro, wr, trap;
    logic [31:0] old, nv;
    logic [63:0] c0, r0;
    int k;
    if (rst) begin
      mm_ie = 0; mm_pie = 0; mm_mie = 0; mm_tvec = 0; mm_scr = 0;
      mm_epc = 0; mm_cause = 0; mm_cyc = 0; mm_ret = 0; irq_d1 = 0; irq_d2 = 0;
      return;
    end
    m_lookup(addr, mp, ro, old);
    k    = m_idx();
    trap = int_taken && mm_ie && k >= 0;
    wr   = csr_op != 2'b00 && !m_illegal(mp, ro) &&
           !(csr_op != 2'b01 && wd == 32'd0) && !trap;
    if (wr && addr == 12'h300 && int_ret) wr = 1'b0;
    case (csr_op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      default: nv = old & ~wd;
    endcase
    c0 = mm_cyc;
    r0 = mm_ret;
    mm_cyc = mm_cyc + 64'd1;
    if (instr_retire) mm_ret = mm_ret + 64'd1;
    if (wr) begin
      case (addr)
        12'h300: begin mm_ie = nv[3]; mm_pie = nv[7]; end
        12'h304: mm_mie = nv & MIE_MASK;
        12'h305: mm_tvec = {nv[31:2], 1'b0, nv[1:0] == 2'b01};
        12'h340: mm_scr = nv;
        12'h341: mm_epc = nv & ~32'h3;
        12'h342: mm_cause = nv;
        12'hB00: mm_cyc = {c0[63:32], nv};
        12'hB80: mm_cyc = {nv, c0[31:0]};
        12'hB02: mm_ret = {r0[63:32], nv};
        12'hB82: mm_ret = {nv, r0[31:0]};
        default: ;
      endcase
    end
    if (trap) begin
      mm_epc   = {next_pc[31:2], 2'b00};
      mm_cause = 32'h8000_0000 | 32'(16 + k);
      mm_pie   = mm_ie;
      mm_ie    = 1'b0;
    end else if (int_ret) begin
      mm_ie  = mm_pie;
      mm_pie = 1'b1;
    end
    irq_d2 = irq_d1;
    irq_d1 = irq;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; addr = a; wd = d;
    tick();
    csr_op = 2'b00;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] e);
    csr_op = 2'b00; addr = a;
    #1;
    chk(tag, rd, e);
  endtask

  logic [11:0] alist [17] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                              12'h123, 12'h7C0};

  initial begin
    rst = 1'b1; irq = '0; csr_op = 2'b00; addr = '0; wd = '0; next_pc = '0;
    int_taken = 1'b0; int_ret = 1'b0; instr_retire = 1'b0;
    @(posedge clk);
    m_step();
    #1;
    tick();
    rst = 1'b0;

    // Reset values and free-running cycle counter
    rd_chk("rst_mstatus", 12'h300, 32'd0);
    rd_chk("rst_mtvec", 12'h305, 32'd0);
    rd_chk("rst_mcycle", 12'hB00, 32'd0);
    chk("rst_int_req", int_req, 1'b0);
    chk("rst_int_vec", int_vec, 32'd0);
    repeat (10) tick();
    rd_chk("mcycle10", 12'hB00, 32'd10);

    // Vectored interrupt setup and synchroniser latency
    wr(2'b01, 12'h305, 32'h101);
    wr(2'b01, 12'h304, 32'h0005_0000);
    wr(2'b01, 12'h300, 32'h8);
    irq = 4'b0101;
    tick();
    #1 chk("irq_lat1", int_req, 1'b0);
    tick();
    #1 chk("irq_lat2", int_req, 1'b1);
    chk("vec_idx0", int_vec, 32'h140);

    // Trap entry
    int_taken = 1'b1; next_pc = 32'h2003;
    tick();
    int_taken = 1'b0;
    #1 chk("trap_mepc", mepc, 32'h2000);
    chk("trap_req_off", int_req, 1'b0);
    rd_chk("trap_mcause", 12'h342, 32'h8000_0010);
    rd_chk("trap_mstatus", 12'h300, 32'h80);

    // mret restores MIE
    int_ret = 1'b1;
    tick();
    int_ret = 1'b0;
    rd_chk("ret_mstatus", 12'h300, 32'h88);
    chk("ret_req_on", int_req, 1'b1);

    // Set/clear semantics and read-only handling
    wr(2'b01, 12'h340, 32'h0F);
    wr(2'b10, 12'h340, 32'hF0);
    rd_chk("rs_scratch", 12'h340, 32'hFF);
    wr(2'b11, 12'h340, 32'h0F);
    rd_chk("rc_scratch", 12'h340, 32'hF0);
    csr_op = 2'b01; addr = 12'hC00; wd = 32'h55;
    #1 chk("ro_rw_illegal", csr_illegal, 1'b1);
    tick();
    csr_op = 2'b10; addr = 12'hC00; wd = 32'd0;
    #1 chk("ro_rs0_legal", csr_illegal, 1'b0);
    tick();
    csr_op = 2'b00;

    // Counter carry and wrap
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'd0);
    rd_chk("mcycleh_pre", 12'hB80, 32'd0);
    tick();
    rd_chk("mcycleh_carry", 12'hB80, 32'd1);
    wr(2'b01, 12'hB02, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB82, 32'hFFFF_FFFF);
    instr_retire = 1'b1;
    tick();
    instr_retire = 1'b0;
    rd_chk("minstret_wrap_lo", 12'hB02, 32'd0);
    rd_chk("minstret_wrap_hi", 12'hB82, 32'd0);

    // Trap discards a same-cycle write; int_taken without request is ignored
    #1 chk("pre_trap2_req", int_req, 1'b1);
    int_taken = 1'b1; next_pc = 32'h3008;
    csr_op = 2'b01; addr = 12'h340; wd = 32'd5;
    tick();
    int_taken = 1'b0; csr_op = 2'b00;
    rd_chk("trap_drops_write", 12'h340, 32'hF0);
    chk("trap2_mepc", mepc, 32'h3008);
    int_taken = 1'b1; next_pc = 32'h5550;
    tick();
    int_taken = 1'b0;
    #1 chk("ignored_mepc", mepc, 32'h3008);
    rd_chk("ignored_mcause", 12'h342, 32'h8000_0010);

    // Reset beats a same-cycle write
    rst = 1'b1; csr_op = 2'b01; addr = 12'h340; wd = 32'h77;
    tick();
    rst = 1'b0; csr_op = 2'b00;
    rd_chk("rst_wins_write", 12'h340, 32'd0);
    rd_chk("rst_mcycle0", 12'hB00, 32'd0);
    tick();
    rd_chk("rst_mcycle1", 12'hB00, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      csr_op       = 2'($urandom_range(0, 3));
      addr         = alist[$urandom_range(0, 16)];
      wd           = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom());
      if ($urandom_range(0, 7) == 0) irq = NI'($urandom());
      int_taken    = ($urandom_range(0, 3) == 0);
      int_ret      = ($urandom_range(0, 7) == 0);
      instr_retire = 1'($urandom_range(0, 1));
      next_pc      = 32'($urandom());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
